reg_bank: RTL and testbench

Parametrised register bank that replaces the single-purpose accumulator and B registers of the FPGA computer with NREGS general registers of WIDTH bits. A GO edge selects and arms one register. While the bank is armed, that register can be front-panel programmed, loaded from the shared bus, incremented, or driven onto the bus. It sits between the front-panel programming inputs and the system bus, and reports the armed register's contents on CURRENT for display.

---
 rtl/reg_bank_pkg.sv | 27 ++
 rtl/reg_bank_cell.sv | 22 ++
 rtl/reg_bank.sv | 104 ++++++++++
 tb/tb_reg_bank.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared types and constants for the general register bank
package reg_bank_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_NREGS = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ARMED = 1'b1
   } state_t;

   // Higher encoding wins when several ops are requested in the same cycle
   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_INC  = 2'd1,
      OP_WE   = 2'd2,
      OP_PRGM = 2'd3
   } op_t;

   function automatic op_t pick_op(input logic prgm, input logic we, input logic inc);
      if (prgm)     return OP_PRGM;
      else if (we)  return OP_WE;
      else if (inc) return OP_INC;
      else          return OP_NONE;
   endfunction

endpackage

// File: rtl/reg_bank_cell.sv
// rtl/reg_bank_cell.sv - one WIDTH-bit register with load and increment
module reg_bank_cell #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             inc,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= '0;
      else if (load)
         q <= load_data;
      else if (inc)
         q <= q + WIDTH'(1);
   end

endmodule

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - armed general register bank with front-panel and bus access
module reg_bank
   import reg_bank_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREGS = DEF_NREGS,
   parameter int SELW  = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [SELW-1:0]  sel,
   input  logic             go,
   input  logic             en,
   input  logic             prgm,
   input  logic             we,
   input  logic             inc,
   input  logic             oe,
   input  logic [WIDTH-1:0] prgm_in,
   input  logic [WIDTH-1:0] bus_in,
   output logic [WIDTH-1:0] bus_out,
   output logic             bus_oe,
   output logic [WIDTH-1:0] current,
   output logic [SELW-1:0]  active,
   output logic             armed,
   output logic             err
);

   state_t          state_q, state_d;
   logic [SELW-1:0] active_q, active_d;
   logic            go_q;
   logic            go_rise;
   logic            ops_ok;
   op_t             op;
   logic [WIDTH-1:0] load_data;
   logic [WIDTH-1:0] regs [NREGS];

   assign go_rise = go & ~go_q;
   assign ops_ok  = (state_q == ST_ARMED) & en;

   // go_q resets high so a GO already held through reset is not seen as a rise
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         active_q <= '0;
         go_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         go_q     <= go;
      end
   end

   always_comb begin
      state_d  = state_q;
      active_d = active_q;
      if (go_rise) begin
         if (state_q == ST_IDLE) begin
            state_d  = ST_ARMED;
            active_d = sel;
         end else if (sel != active_q) begin
            active_d = sel;
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   always_comb begin
      op        = ops_ok ? pick_op(prgm, we, inc) : OP_NONE;
      load_data = (op == OP_PRGM) ? prgm_in : bus_in;
   end

   for (genvar i = 0; i < NREGS; i++) begin : g_cell
      logic hit;
      assign hit = (active_q == SELW'(i));

      reg_bank_cell #(.WIDTH(WIDTH)) u_cell (
         .clk       (clk),
         .reset     (reset),
         .load      (hit && (op == OP_PRGM || op == OP_WE)),
         .load_data (load_data),
         .inc       (hit && (op == OP_INC)),
         .q         (regs[i])
      );
   end

   assign current = regs[active_q];
   assign active  = active_q;
   assign armed   = (state_q == ST_ARMED);

   // Bus samples the pre-write value, giving read-before-write on the same edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus_out <= '0;
         bus_oe  <= 1'b0;
         err     <= 1'b0;
      end else begin
         bus_oe  <= ops_ok & oe;
         bus_out <= (ops_ok & oe) ? current : '0;
         err     <= ops_ok & prgm & we;
      end
   end

endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - self-checking bench for reg_bank against a behavioural model
module tb_reg_bank;
   import reg_bank_pkg::*;

   localparam int W = DEF_WIDTH;
   localparam int N = DEF_NREGS;
   localparam int S = $clog2(N);

   logic         clk = 1'b0;
   logic         reset;
   logic [S-1:0] sel;
   logic         go, en, prgm, we, inc, oe;
   logic [W-1:0] prgm_in, bus_in;
   logic [W-1:0] bus_out, current;
   logic         bus_oe, armed, err;
   logic [S-1:0] active;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0] m_reg [N];
   logic         m_armed, m_goq, m_bus_oe, m_err;
   logic [S-1:0] m_active;
   logic [W-1:0] m_bus_out;

   always #5 clk = ~clk;

   reg_bank #(.WIDTH(W), .NREGS(N), .SELW(S)) dut (
      .clk(clk), .reset(reset), .sel(sel), .go(go), .en(en), .prgm(prgm),
      .we(we), .inc(inc), .oe(oe), .prgm_in(prgm_in), .bus_in(bus_in),
      .bus_out(bus_out), .bus_oe(bus_oe), .current(current), .active(active),
      .armed(armed), .err(err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_reg[i] = '0;
      m_armed = 0; m_active = '0; m_goq = 1; m_bus_out = '0; m_bus_oe = 0; m_err = 0;
   endtask

   // One clock edge of the reference behaviour, from the current inputs
   task automatic model_edge();
      logic [W-1:0] cur;
      logic         rise;
      cur  = m_reg[m_active];
      rise = go && !m_goq;
      if (m_armed && en) begin
         m_bus_oe  = oe;
         m_bus_out = oe ? cur : '0;
         m_err     = prgm && we;
         if (prgm)     m_reg[m_active] = prgm_in;
         else if (we)  m_reg[m_active] = bus_in;
         else if (inc) m_reg[m_active] = cur + 1;
      end else begin
         m_bus_oe = 0; m_bus_out = '0; m_err = 0;
      end
      if (rise) begin
         if (!m_armed) begin
            m_armed = 1; m_active = sel;
         end else if (sel != m_active) begin
            m_active = sel;
         end else begin
            m_armed = 0;
         end
      end
      m_goq = go;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".current"}, current, m_reg[m_active]);
      check({tag, ".armed"},   armed,   m_armed);
      check({tag, ".active"},  active,  m_active);
      check({tag, ".bus_oe"},  bus_oe,  m_bus_oe);
      check({tag, ".bus_out"}, bus_out, m_bus_out);
      check({tag, ".err"},     err,     m_err);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic idle_inputs();
      prgm = 0; we = 0; inc = 0; oe = 0;
   endtask

   initial begin
      reset = 1; go = 1; sel = '0; en = 1; idle_inputs();
      prgm_in = '0; bus_in = '0;
      model_reset();
      #23;
      check_all("rst");
      reset = 0;
      step("go_held");
      check("no_arm_after_reset", armed, 1'b0);
      go = 0; step("go_low");
      go = 1; sel = 1; step("arm1");
      check("arm1_armed", armed, 1'b1);
      check("arm1_active", active, 1);
      go = 0;

      prgm = 1; prgm_in = 8'hAA; oe = 1; step("prgm_aa");
      check("prgm_aa_cur", current, 8'hAA);
      check("rbw_bus", bus_out, 8'h00);
      check("rbw_oe", bus_oe, 1'b1);
      prgm = 0; step("oe_hold");
      check("oe_hold_bus", bus_out, 8'hAA);
      oe = 0;

      prgm = 1; prgm_in = 8'hF0; we = 1; bus_in = 8'h0F; step("conflict");
      check("conflict_val", current, 8'hF0);
      check("conflict_err", err, 1'b1);
      prgm = 0; step("we_only");
      check("we_only_val", current, 8'h0F);
      check("err_one_cycle", err, 1'b0);
      we = 0;

      prgm = 1; prgm_in = 8'hFE; step("load_fe");
      prgm = 0; inc = 1; oe = 1;
      step("inc1"); check("inc_ff", current, 8'hFF);
      step("inc2"); check("inc_wrap", current, 8'h00);
      step("inc3"); check("inc_01", current, 8'h01);
      en = 0; step("en_off");
      check("en_off_val", current, 8'h01);
      check("en_off_oe", bus_oe, 1'b0);
      en = 1; idle_inputs();

      go = 1; sel = 2; step("retarget2"); go = 0; step("rt2_low");
      prgm = 1; prgm_in = 8'h55; step("wr55"); prgm = 0;
      check("reg2_55", current, 8'h55);
      go = 1; sel = 1; step("retarget1"); go = 0; step("rt1_low");
      check("reg1_kept", current, 8'h01);
      go = 1; sel = 2; step("retarget2b"); go = 0; step("rt2b_low");
      go = 1; sel = 2; step("disarm"); go = 0;
      check("disarm_state", armed, 1'b0);
      prgm = 1; prgm_in = 8'h99; step("idle_prgm"); prgm = 0;
      check("idle_prgm_ignored", current, 8'h55);

      go = 1; sel = 3; step("arm3"); go = 0;
      prgm = 1; prgm_in = 8'h3C; oe = 1; step("pre_rst");
      @(posedge clk); #3;
      reset = 1; model_reset();
      #1;
      check_all("async_rst");
      check("async_rst_bus_oe", bus_oe, 1'b0);
      check("async_rst_state", armed, 1'b0);
      idle_inputs(); go = 0;
      #3 reset = 0;

      for (int c = 0; c < 3000; c++) begin
         sel     = S'($urandom_range(0, N - 1));
         go      = ($urandom_range(0, 5) == 0);
         en      = ($urandom_range(0, 7) != 0);
         prgm    = ($urandom_range(0, 4) == 0);
         we      = ($urandom_range(0, 3) == 0);
         inc     = ($urandom_range(0, 2) == 0);
         oe      = ($urandom_range(0, 1) == 0);
         prgm_in = W'($urandom);
         bus_in  = W'($urandom);
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
